// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : RISC-V load/store controller for a word-wide, byte-addressed memory
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_ctrl #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        busy,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_RESP = 3'd5
    } state_t;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3[1:0] != 2'b11) && (f3 != 3'b110);
    endfunction

    state_t      state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] w0_q;
    logic [31:0] w1_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_fault_q;

    // Acceptance-time checks on the raw request
    logic [2:0]  w_req_size;
    logic [32:0] w_req_end;
    logic        w_req_fault;
    logic        w_req_sw_aligned;

    assign w_req_size       = size_of(req_funct3);
    assign w_req_end        = {1'b0, req_addr} + 33'(w_req_size);
    assign w_req_fault      = !f3_legal(req_we, req_funct3) || (w_req_end > 33'(MEM_BYTES));
    assign w_req_sw_aligned = req_we && (req_funct3 == 3'b010) && (req_addr[1:0] == 2'b00);

    logic [2:0]  w_size;
    logic [1:0]  w_off;
    logic        w_span;
    logic [31:0] w_a0;
    logic [31:0] w_a1;
    logic [31:0] w_lo;
    logic [31:0] w_hi;
    logic [63:0] w_old;
    logic [3:0]  w_lanes;
    logic [7:0]  w_bmask;
    logic [63:0] w_ins;
    logic [63:0] w_merged;
    logic [31:0] w_shr;
    logic [31:0] w_load;

    assign w_size = size_of(f3_q);
    assign w_off  = addr_q[1:0];
    assign w_span = ({2'b00, w_off} + {1'b0, w_size}) > 4'd4;
    assign w_a0   = {addr_q[31:2], 2'b00};
    assign w_a1   = w_a0 + 32'd4;

    // The word being read this cycle is not yet in w0_q/w1_q, so take it straight from the bus
    assign w_lo  = (state_q == S_RD0) ? mem_rdata : w0_q;
    assign w_hi  = (state_q == S_RD1) ? mem_rdata : w1_q;
    assign w_old = {w_hi, w_lo};

    assign w_lanes = (w_size == 3'd1) ? 4'b0001 : (w_size == 3'd2) ? 4'b0011 : 4'b1111;
    assign w_bmask = {4'b0000, w_lanes} << w_off;
    assign w_ins   = {32'b0, wdata_q} << {w_off, 3'b000};
    assign w_shr   = 32'(w_old >> {w_off, 3'b000});

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < 8; i++) begin
            if (w_bmask[i]) w_merged[8*i +: 8] = w_ins[8*i +: 8];
        end
    end

    always_comb begin
        case (f3_q)
            3'b000:  w_load = {{24{w_shr[7]}}, w_shr[7:0]};
            3'b001:  w_load = {{16{w_shr[15]}}, w_shr[15:0]};
            3'b100:  w_load = {24'b0, w_shr[7:0]};
            3'b101:  w_load = {16'b0, w_shr[15:0]};
            default: w_load = w_shr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= 32'b0;
            wdata_q      <= 32'b0;
            w0_q         <= 32'b0;
            w1_q         <= 32'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'b0;
            mem_wdata_q  <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_fault_q <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'b0;
            mem_wdata_q  <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_fault_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        w0_q    <= 32'b0;
                        w1_q    <= 32'b0;
                        if (w_req_fault) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                        end else if (w_req_sw_aligned) begin
                            state_q     <= S_WR0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q    <= S_RD0;
                            mem_addr_q <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                S_RD0: begin
                    w0_q <= mem_rdata;
                    if (w_span) begin
                        state_q    <= S_RD1;
                        mem_addr_q <= w_a1;
                    end else if (we_q) begin
                        state_q     <= S_WR0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= w_a0;
                        mem_wdata_q <= w_merged[31:0];
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= w_load;
                    end
                end
                S_RD1: begin
                    w1_q <= mem_rdata;
                    if (we_q) begin
                        state_q     <= S_WR0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= w_a0;
                        mem_wdata_q <= w_merged[31:0];
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= w_load;
                    end
                end
                S_WR0: begin
                    if (w_span) begin
                        state_q     <= S_WR1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= w_a1;
                        mem_wdata_q <= w_merged[63:32];
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                S_WR1: begin
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign busy       = (state_q != S_IDLE);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;

endmodule

`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller between the execute stage and the byte-addressed data memory.
- The data memory writes only whole 32-bit little-endian words and reads combinationally.
- This block turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned memory reads and writes.
- It handles sign/zero extension, read-modify-write for sub-word stores, splitting of misaligned accesses that span two words, and range/funct3 fault reporting, all behind a valid/ready handshake.

Parameters:
- MEM_BYTES, 1024, bytes of backing data memory; the legal range is byte addresses 0..MEM_BYTES-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; only the low bytes are used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid.
- busy  out  1  high whenever not IDLE; stalls the pipeline.
- mem_we  out  1  to data memory write enable.
- mem_addr  out  32  to data memory; always a multiple of 4.
- mem_wdata  out  32  to data memory write data.
- mem_rdata  in  32  from data memory; combinational read of mem_addr.

Behaviour:
- Reset: on rst high, asynchronously enter IDLE.
  - req_ready=0 while rst is high, then 1 in IDLE.
  - All other outputs 0; internal latches cleared.
- Reset mid-operation aborts the access. If WR0 already completed, word0 stays written; this is acceptable and is not rolled back.
- Handshake: the request is accepted on an edge where req_valid && req_ready. At acceptance, latch we, funct3, addr and wdata. Inputs are ignored while busy.
- Derived values:
  - size = 1/2/4 from funct3[1:0].
  - A0 = addr & ~3; A1 = A0 + 4; off = addr[1:0].
  - span = (off + size > 4).
- Fault conditions, evaluated at acceptance:
  - funct3 is not legal for the direction.
  - addr + size > MEM_BYTES, computed in 33 bits (no wrap).
  - On fault, go directly to RESP with resp_fault=1, resp_rdata=0, and make no memory access.
- FSM states: IDLE, RD0, RD1, WR0, WR1, RESP.
- Transitions from IDLE on accept:
  - fault → RESP.
  - SW with off=0 → WR0 (no read needed).
  - all others → RD0.
- RD0: mem_addr=A0, mem_we=0; capture mem_rdata into w0. Next state: span → RD1; else store → WR0; else load → RESP.
- RD1: mem_addr=A1, mem_we=0; capture w1. Next state: store → WR0, load → RESP.
- WR0: mem_addr=A0, mem_we=1. mem_wdata = w0 with bytes off..min(3, off+size-1) replaced by the low bytes of wdata, in little-endian order. For aligned SW, mem_wdata = wdata. Next state: span → WR1; else RESP.
- WR1: mem_addr=A1, mem_we=1. mem_wdata = w1 with bytes 0..(off+size-5) replaced by the remaining high bytes of wdata. Next state: RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready stays 0 in RESP.
- Load assembly: take the 64-bit value {w1, w0} shifted right by 8*off, keep the low size bytes, then:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through unchanged.
- Bus rules: in IDLE and RESP, mem_we=0, mem_addr=0, mem_wdata=0. mem_* are registered-state decodes and must be glitch-free on the edge.
- Accept-to-resp_valid latency in cycles, with acceptance at edge E0 and the count giving the cycle after E0 in which resp_valid is high:
  - fault: 1
  - aligned SW: 2
  - non-span load: 2
  - span load: 3
  - non-span sub-word store or misaligned SW: 3
  - span store: 5
- Back-to-back: the next request can be accepted on the edge that leaves RESP.

Test Plan:
- Memory bytes 0x10..0x13 = 78 56 34 12. LW addr 0x10 → one RD0 cycle with mem_addr=0x10; resp_rdata=0x12345678, fault 0, resp_valid high 2 cycles after acceptance.
- Bytes 0x20..0x23 = 80 FF 7F 01. LB 0x20 → 0xFFFFFF80. LBU 0x20 → 0x00000080. LH 0x22 → 0x0000017F.
- Bytes 0x30..0x37 = 11 22 33 AA BB 44 55 66. LHU 0x33 (span) → reads 0x30 then 0x34; resp_rdata=0x0000BBAA; resp_valid 3 cycles after acceptance.
- Word at 0x40 = 0xDDCCBBAA. SB addr 0x41, wdata 0x000000EE → RD0 then WR0 writes 0xDDCCEEAA to 0x40; resp_fault=0.
- Words at 0x50 and 0x54 = 0. SW 0x52, wdata 0x44332211 → WR0 writes 0x22110000 to 0x50; WR1 writes 0x00004433 to 0x54; resp_valid 5 cycles after acceptance.
- Faults:
  - LW 0x3FE → resp_fault=1 the cycle after acceptance, mem_we never asserted.
  - funct3=011 load → fault.
  - Assert rst during WR1 of the previous case → outputs 0 immediately, state IDLE, word 0x54 unchanged.
